// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
package ccff_loader_pkg;

  localparam int CFG_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int bytes_for(input int bits);
    return (bits + CFG_BYTE_W - 1) / CFG_BYTE_W;
  endfunction

endpackage

// File: rtl/ccff_byte_serializer.sv
// Byte-to-bit serializer: one holding register in front of a shift register.
// Exposes the post-edge bit/valid so the parent can register its outputs with no extra latency.
module ccff_byte_serializer
  import ccff_loader_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_clr,
  input  logic [CFG_BYTE_W-1:0] i_data,
  input  logic                  i_valid,
  input  logic                  i_pop,
  output logic                  o_hold_empty,
  output logic                  o_nxt_vld,
  output logic                  o_nxt_bit
);

  localparam int CW = $clog2(CFG_BYTE_W + 1);
  localparam logic [CW-1:0] FULL = CW'(CFG_BYTE_W);

  logic [CFG_BYTE_W-1:0] r_hold, r_shift;
  logic                  r_hold_vld;
  logic [CW-1:0]         r_cnt;

  logic [CFG_BYTE_W-1:0] w_hold_n, w_shift_n, w_shift_pop;
  logic                  w_hold_vld_n, w_empty;
  logic [CW-1:0]         w_cnt_n, w_cnt_pop;

  always_comb begin
    w_cnt_pop    = (i_pop && r_cnt != '0) ? CW'(r_cnt - CW'(1)) : r_cnt;
    w_shift_pop  = i_pop ? {r_shift[CFG_BYTE_W-2:0], 1'b0} : r_shift;
    w_empty      = (w_cnt_pop == '0);
    w_shift_n    = w_shift_pop;
    w_cnt_n      = w_cnt_pop;
    w_hold_n     = r_hold;
    w_hold_vld_n = r_hold_vld;
    if (i_clr) begin
      w_shift_n    = '0;
      w_cnt_n      = '0;
      w_hold_n     = '0;
      w_hold_vld_n = 1'b0;
    end else if (w_empty && r_hold_vld) begin
      w_shift_n    = r_hold;
      w_cnt_n      = FULL;
      w_hold_n     = i_valid ? i_data : r_hold;
      w_hold_vld_n = i_valid;
    end else if (w_empty && i_valid) begin
      // Bypass the holding register so the first bit is out one cycle after acceptance.
      w_shift_n    = i_data;
      w_cnt_n      = FULL;
    end else if (i_valid) begin
      w_hold_n     = i_data;
      w_hold_vld_n = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    r_hold     <= w_hold_n;
    r_hold_vld <= w_hold_vld_n;
    r_shift    <= w_shift_n;
    r_cnt      <= w_cnt_n;
  end

  assign o_hold_empty = ~r_hold_vld;
  assign o_nxt_vld    = (w_cnt_n != '0);
  assign o_nxt_bit    = w_shift_n[CFG_BYTE_W-1];

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises host bitstream bytes MSB-first into the config chain head, gates the chain
// clock per shifted bit, and counts ones seen at the chain tail.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  input  logic                  start,
  input  logic [CFG_BYTE_W-1:0] cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  ccff_head,
  output logic                  ccff_clk_en,
  input  logic                  ccff_tail,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      tail_ones
);

  localparam int NBYTES = bytes_for(CHAIN_LEN);
  localparam int BW     = $clog2(NBYTES + 1);

  state_e           r_state, w_state_n;
  logic [CNT_W-1:0] r_rem, r_ones, w_rem_n;
  logic [BW-1:0]    r_nbytes;
  logic             r_head, r_clk_en;

  logic w_fire, w_pop, w_last, w_enter, w_clr, w_en_n;
  logic w_hold_empty, w_nxt_vld, w_nxt_bit;

  ccff_byte_serializer u_ser (
    .i_clk        (prog_clk),
    .i_clr        (w_clr),
    .i_data       (cfg_data),
    .i_valid      (w_fire),
    .i_pop        (w_pop),
    .o_hold_empty (w_hold_empty),
    .o_nxt_vld    (w_nxt_vld),
    .o_nxt_bit    (w_nxt_bit)
  );

  assign cfg_ready = (r_state == LOAD) && w_hold_empty && (r_nbytes < BW'(NBYTES));
  assign w_fire    = cfg_valid && cfg_ready;
  // The chain captures on every edge where the gate was open, so that edge consumes a bit.
  assign w_pop     = r_clk_en;
  assign w_rem_n   = w_pop ? CNT_W'(r_rem - CNT_W'(1)) : r_rem;
  assign w_last    = w_pop && (r_rem == CNT_W'(1));
  assign w_enter   = start && (r_state != LOAD);
  // Leftover LSBs of the final byte are dropped by clearing on completion.
  assign w_clr     = prog_reset || w_enter || w_last;

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_n = LOAD;
      LOAD:    if (w_last) w_state_n = DONE;
      DONE:    if (start)  w_state_n = LOAD;
      default: w_state_n = IDLE;
    endcase
  end

  assign w_en_n = (w_state_n == LOAD) && w_nxt_vld && (w_rem_n != '0);

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      r_state  <= IDLE;
      r_rem    <= '0;
      r_ones   <= '0;
      r_nbytes <= '0;
      r_head   <= 1'b0;
      r_clk_en <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_clk_en <= w_en_n;
      if (w_en_n) r_head <= w_nxt_bit;
      if (w_enter) begin
        r_rem    <= CNT_W'(CHAIN_LEN);
        r_ones   <= '0;
        r_nbytes <= '0;
      end else begin
        r_rem <= w_rem_n;
        if (w_pop && ccff_tail && r_ones != CNT_W'(CHAIN_LEN))
          r_ones <= CNT_W'(r_ones + CNT_W'(1));
        if (w_fire) r_nbytes <= BW'(r_nbytes + BW'(1));
      end
    end
  end

  assign ccff_head   = r_head;
  assign ccff_clk_en = r_clk_en;
  assign busy        = (r_state == LOAD);
  assign done        = (r_state == DONE);
  assign tail_ones   = r_ones;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader at chain lengths 8, 10 and 16, each with a behavioural chain model.
module tb_ccff_chain_loader;

  logic        prog_clk, prog_reset;
  logic        st[3];
  logic [7:0]  dat[3];
  logic        vld[3];
  logic        rdy[3], head[3], en[3], tail[3], bsy[3], dn[3];
  logic [4:0]  ones[3];
  logic [15:0] chain_rd[3];
  logic        pre_ld;
  logic [15:0] pre_val;
  int          act;

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int L  = (g == 0) ? 8 : ((g == 1) ? 10 : 16);
    localparam int CW = $clog2(L + 1);
    logic [CW-1:0] w_ones;
    logic [15:0]   chain;

    ccff_chain_loader #(.CHAIN_LEN(L)) dut (
      .prog_clk    (prog_clk),
      .prog_reset  (prog_reset),
      .start       (st[g]),
      .cfg_data    (dat[g]),
      .cfg_valid   (vld[g]),
      .cfg_ready   (rdy[g]),
      .ccff_head   (head[g]),
      .ccff_clk_en (en[g]),
      .ccff_tail   (tail[g]),
      .busy        (bsy[g]),
      .done        (dn[g]),
      .tail_ones   (w_ones)
    );

    assign ones[g]     = 5'(w_ones);
    assign tail[g]     = chain[L-1];
    assign chain_rd[g] = chain;

    always @(posedge prog_clk)
      if (pre_ld && act == g) chain <= pre_val;
      else if (en[g])         chain <= {chain[14:0], head[g]};
  end

  initial begin
    prog_clk = 1'b0;
    forever #5 prog_clk = ~prog_clk;
  end

  typedef struct {
    logic [7:0]  data;
    logic [15:0] pre;
    int          exp_ones;
  } vec_t;

  int checks, failures;
  int cycn, en_cnt, run, max_run, last_en_cyc, left;
  bit q[$];
  vec_t tbl[5];

  function automatic int len_of(input int k);
    return (k == 0) ? 8 : ((k == 1) ? 10 : 16);
  endfunction

  task automatic chk(input string name, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, a, e, $time);
    end
  endtask

  // One clock; scoreboard pops the expected bit on every gated-clock cycle.
  task automatic cyc();
    bit e;
    @(negedge prog_clk);
    cycn++;
    if (en[act]) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL head_unexpected actual=%0d expected=none", head[act]);
      end else begin
        e = q.pop_front();
        chk("head_bit", int'(head[act]), int'(e));
      end
      en_cnt++;
      run++;
      last_en_cyc = cycn;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  endtask

  task automatic begin_load(input int k, input logic [15:0] pre);
    act = k;
    pre_val = pre;
    pre_ld = 1'b1;
    cyc();
    pre_ld = 1'b0;
    q.delete();
    left = len_of(k);
    en_cnt = 0; run = 0; max_run = 0;
    st[k] = 1'b1;
    cyc();
    st[k] = 1'b0;
  endtask

  task automatic send(input int k, input logic [7:0] b);
    for (int n = 0; n < 100 && !rdy[k]; n++) cyc();
    if (!rdy[k]) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    dat[k] = b;
    vld[k] = 1'b1;
    for (int i = 7; i >= 0 && left > 0; i--) begin
      q.push_back(b[i]);
      left--;
    end
    cyc();
    vld[k] = 1'b0;
  endtask

  task automatic wait_done(input int k);
    for (int n = 0; n < 300 && !dn[k]; n++) cyc();
    if (!dn[k]) chk("done_timeout", 0, 1);
  endtask

  initial begin
    checks = 0; failures = 0; cycn = 0; act = 0;
    en_cnt = 0; run = 0; max_run = 0; last_en_cyc = 0; left = 0;
    pre_ld = 1'b0; pre_val = '0;
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0; dat[k] = '0; vld[k] = 1'b0;
    end
    prog_reset = 1'b1;
    st[0] = 1'b1;  // reset wins over start
    repeat (3) cyc();
    st[0] = 1'b0;
    chk("rst_ready", int'(rdy[0]), 0);
    chk("rst_head", int'(head[0]), 0);
    chk("rst_clk_en", int'(en[0]), 0);
    chk("rst_busy", int'(bsy[0]), 0);
    chk("rst_done", int'(dn[0]), 0);
    chk("rst_ones", int'(ones[0]), 0);
    prog_reset = 1'b0;
    cyc();
    chk("idle_busy", int'(bsy[0]), 0);

    tbl[0] = '{8'hA5, 16'h0000, 0};
    tbl[1] = '{8'h00, 16'h000F, 4};
    tbl[2] = '{8'hFF, 16'h00FF, 8};
    tbl[3] = '{8'h3C, 16'h0081, 2};
    tbl[4] = '{8'h5A, 16'h00A5, 4};
    for (int v = 0; v < 5; v++) begin
      begin_load(0, tbl[v].pre);
      chk("load_busy", int'(bsy[0]), 1);
      chk("load_ones_clr", int'(ones[0]), 0);
      chk("load_clk_en_idle", int'(en[0]), 0);
      send(0, tbl[v].data);
      wait_done(0);
      chk("bit_count", en_cnt, 8);
      chk("done_latency", cycn - last_en_cyc, 1);
      chk("tail_ones", int'(ones[0]), tbl[v].exp_ones);
      chk("chain_value", int'(chain_rd[0][7:0]), int'(tbl[v].data));
      chk("ready_after", int'(rdy[0]), 0);
      chk("busy_after", int'(bsy[0]), 0);
      chk("sb_empty", q.size(), 0);
      cyc();
      chk("clk_en_after", int'(en[0]), 0);
    end

    // Length 10 with idle gaps on cfg_valid.
    begin_load(1, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("gap0_clk_en", int'(en[1]), 0);
    end
    send(1, 8'hFF);
    for (int i = 0; i < 11; i++) begin
      cyc();
      if (i >= 8) begin
        chk("gap1_clk_en", int'(en[1]), 0);
        chk("gap1_busy", int'(bsy[1]), 1);
        chk("gap1_ready", int'(rdy[1]), 1);
      end
    end
    send(1, 8'hC0);
    chk("no_third_ready", int'(rdy[1]), 0);
    chk("second_clk_en", int'(en[1]), 1);
    wait_done(1);
    chk("len10_bits", en_cnt, 10);
    chk("len10_chain", int'(chain_rd[1][9:0]), 10'h3FF);
    chk("len10_sb_empty", q.size(), 0);
    dat[1] = 8'h55;
    vld[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("done_ready", int'(rdy[1]), 0);
      chk("done_clk_en", int'(en[1]), 0);
    end
    vld[1] = 1'b0;

    // Reset in the middle of a load, then a clean reload.
    begin_load(0, 16'h0000);
    send(0, 8'hA5);
    for (int n = 0; n < 20 && en_cnt < 3; n++) cyc();
    cyc();
    prog_reset = 1'b1;
    q.delete();
    cyc();
    prog_reset = 1'b0;
    chk("mid_rst_ready", int'(rdy[0]), 0);
    chk("mid_rst_head", int'(head[0]), 0);
    chk("mid_rst_clk_en", int'(en[0]), 0);
    chk("mid_rst_busy", int'(bsy[0]), 0);
    chk("mid_rst_done", int'(dn[0]), 0);
    chk("mid_rst_ones", int'(ones[0]), 0);
    begin_load(0, 16'h0000);
    send(0, 8'h96);
    wait_done(0);
    chk("reload_bits", en_cnt, 8);
    chk("reload_chain", int'(chain_rd[0][7:0]), 8'h96);

    // start ignored in LOAD; honoured in DONE.
    begin_load(0, 16'h0000);
    send(0, 8'hC3);
    cyc();
    st[0] = 1'b1;
    cyc();
    st[0] = 1'b0;
    chk("start_in_load_busy", int'(bsy[0]), 1);
    wait_done(0);
    chk("start_in_load_bits", en_cnt, 8);
    chk("start_in_load_chain", int'(chain_rd[0][7:0]), 8'hC3);
    en_cnt = 0;
    left = 8;
    st[0] = 1'b1;
    cyc();
    st[0] = 1'b0;
    chk("restart_done", int'(dn[0]), 0);
    chk("restart_busy", int'(bsy[0]), 1);
    chk("restart_ones", int'(ones[0]), 0);
    send(0, 8'h3C);
    wait_done(0);
    chk("restart_bits", en_cnt, 8);
    chk("restart_chain", int'(chain_rd[0][7:0]), 8'h3C);
    chk("restart_tail_ones", int'(ones[0]), 4);

    // Length 16, back-to-back bytes stream with no gated-clock bubble.
    begin_load(2, 16'h0000);
    send(2, 8'h96);
    send(2, 8'h3C);
    wait_done(2);
    chk("len16_bits", en_cnt, 16);
    chk("len16_run", max_run, 16);
    chk("len16_chain", int'(chain_rd[2]), 16'h963C);
    chk("len16_sb_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
